// File: rtl/compmag_seq_if.sv
// rtl/compmag_seq_if.sv - start/operand/result bundle for the digit-serial comparator
// master drives start and operands; slave (the comparator) drives status and flags.
interface compmag_seq_if #(
    parameter int WIDTH = 7
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             aeqb;
    logic             agtb;
    logic             altb;

    modport master (
        output start, a, b,
        input  busy, done, aeqb, agtb, altb
    );

    modport slave (
        input  start, a, b,
        output busy, done, aeqb, agtb, altb
    );
endinterface

// File: rtl/compmag_seq.sv
// rtl/compmag_seq.sv - digit-serial MSB-first magnitude comparator with early exit
// Optional macro COMPMAG_SIGNED_EN selects two's-complement ordering; default is unsigned.
module compmag_seq #(
    parameter int WIDTH = 7,
    parameter int DIGIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    compmag_seq_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("compmag_seq: WIDTH must be >= 2 and an integer multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_aeqb;
    logic             r_agtb;
    logic             r_altb;

    logic [DIGIT-1:0] w_flip;
    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;
    logic             w_differ;
    logic             w_gt;

`ifdef COMPMAG_SIGNED_EN
    // Inverting the sign bit maps two's complement onto offset binary, so the
    // unsigned digit compare below orders signed values correctly.
    localparam logic [DIGIT-1:0] SIGN_MASK = DIGIT'(1) << (DIGIT - 1);
    assign w_flip = (r_cnt == '0) ? SIGN_MASK : '0;
`else
    assign w_flip = '0;
`endif

    assign w_da     = r_a[WIDTH-1 -: DIGIT] ^ w_flip;
    assign w_db     = r_b[WIDTH-1 -: DIGIT] ^ w_flip;
    assign w_differ = (w_da != w_db);
    assign w_gt     = (w_da > w_db);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_aeqb  <= 1'b0;
            r_agtb  <= 1'b0;
            r_altb  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_cnt   <= '0;
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_a   <= r_a << DIGIT;
                    r_b   <= r_b << DIGIT;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_differ) begin
                        r_aeqb  <= 1'b0;
                        r_agtb  <= w_gt;
                        r_altb  <= ~w_gt;
                        r_state <= S_DONE;
                    end else if (r_cnt == LAST_DIGIT) begin
                        r_aeqb  <= 1'b1;
                        r_agtb  <= 1'b0;
                        r_altb  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state == S_CMP);
    assign bus.done = (r_state == S_DONE);
    assign bus.aeqb = r_aeqb;
    assign bus.agtb = r_agtb;
    assign bus.altb = r_altb;
endmodule

// File: tb/tb_compmag_seq.sv
// tb/tb_compmag_seq.sv - randomized bench for compmag_seq against an arithmetic reference
// Two instances: WIDTH=7/DIGIT=1 and WIDTH=16/DIGIT=4; honours COMPMAG_SIGNED_EN.
module tb_compmag_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    compmag_seq_if #(.WIDTH(7))  if7 ();
    compmag_seq_if #(.WIDTH(16)) if16 ();

    compmag_seq #(.WIDTH(7),  .DIGIT(1)) u_dut7  (.clk(clk), .rst_n(rst_n), .bus(if7.slave));
    compmag_seq #(.WIDTH(16), .DIGIT(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

    int n_cmp = 0;
    int n_bad = 0;
    int ecnt  = 0;

    // Reference state per instance: one outstanding comparison at most.
    bit         pend   [2];
    int         acc_e  [2];
    int         due_e  [2];
    logic [2:0] pflags [2];
    logic [2:0] lflags [2];
    int         wid    [2] = '{7, 16};
    int         dig    [2] = '{1, 4};

    // flags = {aeqb, agtb, altb}; lat = edges from acceptance to the deciding edge
    function automatic void model(input int w, input int d, input logic [15:0] a,
                                  input logic [15:0] b, output int lat, output logic [2:0] flags);
        int ua, ub, sa, sb, n, da, db;
        ua  = int'(a) & ((1 << w) - 1);
        ub  = int'(b) & ((1 << w) - 1);
        n   = w / d;
        lat = n;
        for (int k = 0; k < n; k++) begin
            da = (ua >> (w - (k + 1) * d)) & ((1 << d) - 1);
            db = (ub >> (w - (k + 1) * d)) & ((1 << d) - 1);
            if (da != db) begin
                lat = k + 1;
                break;
            end
        end
`ifdef COMPMAG_SIGNED_EN
        sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
`else
        sa = ua;
        sb = ub;
`endif
        flags = (sa == sb) ? 3'b100 : ((sa > sb) ? 3'b010 : 3'b001);
    endfunction

    logic        m_start [2];
    logic [15:0] m_a     [2];
    logic [15:0] m_b     [2];
    int          m_lat;
    logic [2:0]  m_f;

    always @(posedge clk) begin
        ecnt++;
        m_start[0] = if7.start;  m_a[0] = {9'd0, if7.a}; m_b[0] = {9'd0, if7.b};
        m_start[1] = if16.start; m_a[1] = if16.a;        m_b[1] = if16.b;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                pend[i]   = 1'b0;
                lflags[i] = 3'b000;
            end else if (!pend[i] && m_start[i]) begin
                model(wid[i], dig[i], m_a[i], m_b[i], m_lat, m_f);
                pend[i]   = 1'b1;
                acc_e[i]  = ecnt;
                due_e[i]  = ecnt + m_lat;
                pflags[i] = m_f;
            end else if (pend[i] && ecnt == due_e[i] + 1) begin
                lflags[i] = pflags[i];
                pend[i]   = 1'b0;
            end
        end
    end

    logic [4:0] c_obs, c_exp;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            c_obs = (i == 0) ? {if7.busy, if7.done, if7.aeqb, if7.agtb, if7.altb}
                             : {if16.busy, if16.done, if16.aeqb, if16.agtb, if16.altb};
            if (!rst_n) c_exp = 5'b0;
            else begin
                c_exp[4]   = pend[i] && ecnt >= acc_e[i] && ecnt < due_e[i];
                c_exp[3]   = pend[i] && ecnt == due_e[i];
                c_exp[2:0] = (pend[i] && ecnt >= due_e[i]) ? pflags[i] : lflags[i];
            end
            n_cmp++;
            if (c_obs !== c_exp) begin
                n_bad++;
                $display("FAIL outputs dut%0d edge %0d: busy/done/eq/gt/lt got %b expected %b",
                         i, ecnt, c_obs, c_exp);
            end
            n_cmp++;
            if (c_obs[4] && c_obs[3]) begin
                n_bad++;
                $display("FAIL busy_and_done dut%0d edge %0d: got both high expected exclusive", i, ecnt);
            end
        end
    end

    task automatic pin(input string name, input int w, input int d, input logic [15:0] a,
                       input logic [15:0] b, input int exp_lat, input logic [2:0] exp_f);
        int lat;
        logic [2:0] f;
        model(w, d, a, b, lat, f);
        n_cmp++;
        if (lat != exp_lat || f !== exp_f) begin
            n_bad++;
            $display("FAIL pin_%s: got lat=%0d flags=%b expected lat=%0d flags=%b",
                     name, lat, f, exp_lat, exp_f);
        end
    endtask

    task automatic wait_idle(input int idx);
        int t = 0;
        while (pend[idx] && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (pend[idx]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout dut%0d: got still busy expected done within 40 cycles", idx);
        end
    endtask

    task automatic go(input int idx, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        if (idx == 0) begin if7.a = a[6:0]; if7.b = b[6:0]; if7.start = 1'b1; end
        else          begin if16.a = a;     if16.b = b;     if16.start = 1'b1; end
        @(negedge clk);
        if7.start  = 1'b0;
        if16.start = 1'b0;
        wait_idle(idx);
    endtask

    logic [15:0] ra, rb;
    initial begin
        if7.start = 1'b0;  if7.a = '0;  if7.b = '0;
        if16.start = 1'b0; if16.a = '0; if16.b = '0;

        pin("gt_100_37", 7, 1, 16'd100, 16'd37, 1, 3'b010);
        pin("eq_85",     7, 1, 16'd85,  16'd85, 7, 3'b100);
        pin("lt_0_1",    7, 1, 16'd0,   16'd1,  7, 3'b001);
`ifdef COMPMAG_SIGNED_EN
        pin("7f_01",     7, 1, 16'h7F,  16'h01, 1, 3'b001);
`else
        pin("7f_01",     7, 1, 16'h7F,  16'h01, 1, 3'b010);
`endif
        pin("hex_digit", 16, 4, 16'h1234, 16'h1243, 3, 3'b001);

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        go(0, 16'd100, 16'd37);
        go(0, 16'd85, 16'd85);
        go(0, 16'd0, 16'd1);
        go(0, 16'h7F, 16'h01);

        // Abort a comparison with an asynchronous reset mid-flight
        @(negedge clk);
        if7.a = 7'd0; if7.b = 7'd1; if7.start = 1'b1;
        @(negedge clk);
        if7.start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin pend[i] = 1'b0; lflags[i] = 3'b000; end
        #1;
        n_cmp++;
        if ({if7.busy, if7.done, if7.aeqb, if7.agtb, if7.altb} !== 5'b0) begin
            n_bad++;
            $display("FAIL async_reset: got %b expected 00000",
                     {if7.busy, if7.done, if7.aeqb, if7.agtb, if7.altb});
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        if7.a = 7'd5; if7.b = 7'd5; if7.start = 1'b1;
        @(negedge clk);
        if7.start = 1'b0;
        wait_idle(0);

        // start held high, operands churning every cycle
        @(negedge clk);
        if7.start = 1'b1;
        repeat (80) begin
            if7.a = 7'($urandom);
            if7.b = 7'($urandom);
            @(negedge clk);
        end
        if7.start = 1'b0;
        wait_idle(0);

        // random start pattern on the 7-bit instance
        repeat (200) begin
            if7.start = 1'($urandom);
            if7.a = 7'($urandom);
            if7.b = ($urandom_range(0, 3) == 0) ? if7.a : 7'($urandom);
            @(negedge clk);
        end
        if7.start = 1'b0;
        wait_idle(0);

        repeat (500) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ 16'($urandom_range(1, 15));
                2:       rb = ra ^ (16'($urandom_range(1, 15)) << 4 * $urandom_range(0, 3));
                default: rb = 16'($urandom);
            endcase
            go(1, ra, rb);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/compmag_seq.md
COMPMAG_SEQ -- requirements
Module: compmag_seq

Interface
REQ-001 Parameter WIDTH, default 7: operand width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 1: bits compared per clock cycle; WIDTH SHALL be an integer multiple of DIGIT, and elaboration SHALL fail otherwise.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to compare; sampled only in IDLE.
REQ-006 a  input  WIDTH  operand A; captured on an accepted start.
REQ-007 b  input  WIDTH  operand B; captured on an accepted start.
REQ-008 busy  output  1  high while a comparison is in progress.
REQ-009 done  output  1  one-cycle pulse marking a new result.
REQ-010 aeqb  output  1  A equal to B.
REQ-011 agtb  output  1  A greater than B.
REQ-012 altb  output  1  A less than B.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CMP and DONE, with N = WIDTH/DIGIT digits per comparison.
REQ-014 IDLE with start=1 at a rising edge: capture a and b into internal shift registers, clear the digit counter, enter CMP, and drive busy=1 from that edge.
REQ-015 IDLE with start=0: remain in IDLE; the outputs SHALL hold their values.
REQ-016 CMP: each cycle compares the most-significant remaining DIGIT bits of A and B (digit k, k=0..N-1, MSB-first), then shifts both registers left by DIGIT bits.
REQ-017 Early termination: on the first digit k where A and B differ, the block SHALL register agtb/altb from that digit's comparison, clear aeqb, and enter DONE at that same edge.
REQ-018 When digit N-1 is equal, the block SHALL register aeqb=1, agtb=0, altb=0 and enter DONE.
REQ-019 Latency: done SHALL be high in the cycle following edge k+1 after start was accepted, where k is the deciding digit; the maximum is N cycles.
REQ-020 DONE: done=1 and busy=0 for exactly one cycle, then return unconditionally to IDLE; start SHALL be ignored in DONE.
REQ-021 Result flags SHALL update only on the edge entering DONE and hold until the next completion; after any completion exactly one flag SHALL be high.
REQ-022 start asserted in CMP or DONE SHALL be ignored and not queued.
REQ-023 Changes on a and b while busy=1 SHALL NOT affect the result in progress.
REQ-024 busy and done SHALL never be high simultaneously.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, busy=0, done=0, aeqb=0, agtb=0, altb=0, and clear the digit counter and shift registers.
REQ-026 Reset asserted mid-comparison SHALL discard the comparison; no done pulse SHALL follow the release of reset.
REQ-027 The first start after reset release SHALL be accepted at the first rising edge at which rst_n=1.

Configuration
REQ-028 Macro COMPMAG_SIGNED_EN defined: a and b SHALL be compared as two's-complement values, with the sign bit's ordering inverted within digit 0 only.
REQ-029 Macro COMPMAG_SIGNED_EN undefined: a and b SHALL be compared as unsigned values; timing and handshake SHALL be identical in both builds.

Verification (WIDTH=7, DIGIT=1 unless stated)
REQ-030 a=100, b=37, start pulse -> done after 1 cycle with agtb=1, aeqb=0, altb=0.
REQ-031 a=85, b=85 -> done after 7 cycles with aeqb=1; a=0, b=1 -> done after 7 cycles with altb=1.
REQ-032 a=7'h7F, b=7'h01 -> altb=1 with COMPMAG_SIGNED_EN defined, agtb=1 without it.
REQ-033 a=0, b=1 started, rst_n pulsed low at cycle 3 -> all outputs 0 at once, no done pulse, a following start with a=5, b=5 completes normally with aeqb=1.
REQ-034 start held high continuously with a and b changed every cycle while busy -> one result per IDLE-CMP-DONE pass, each using the operands captured at acceptance.
REQ-035 WIDTH=16, DIGIT=4, 500 random operand pairs checked against a behavioural model -> 0 errors, each done within 4 cycles.
